instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Sequential instruction-fetch front end for the single-issue MIPS datapath. Holds the program counter, fetches 32-bit words from instruction memory over a request/acknowledge handshake, and presents the instruction and its 6-bit opcode field `op_instruction` to `control_unit`. Consumes the resulting `branch`/`jump` decisions plus the ALU `zero` flag to select the next PC.

## Interface

- `PC_RESET`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory response valid; qualifies `imem_rdata`.
- `imem_rdata`  in  32  fetched instruction word.
- `instruction`  out  32  instruction register (IR).
- `op_instruction`  out  6  `instruction[31:26]`, feeds `control_unit`.
- `instr_valid`  out  1  IR holds a valid, not-yet-consumed instruction.
- `stall`  in  1  downstream not ready; holds IR and PC.
- `branch`  in  1  from `control_unit`; sampled only at consume.
- `jump`  in  1  from `control_unit`; sampled only at consume.
- `zero`  in  1  ALU equality flag; sampled only at consume.
- `pc`  out  32  address of the instruction in IR (or being fetched).
- `retired_cnt`  out  32  consumed-instruction counter (see Configuration).
- `stall_cnt`  out  32  stalled-cycle counter (see Configuration).

## Operation

- FSM, two states: FETCH, VALID.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `instr_valid`=0. On `imem_ack`=1: IR <= `imem_rdata`, go VALID. Without ack: remain, request and address held stable.
- VALID: `imem_req`=0, `instr_valid`=1. Consume event = VALID && !`stall`. On consume: `pc` <= next PC, go FETCH. While `stall`=1: IR, `pc` unchanged.
- Next PC (all 32-bit, wrap modulo 2^32, no overflow flag); `pc4` = `pc`+4:
  - `jump`=1: {`pc4`[31:28], IR[25:0], 2'b00} (jump has priority over branch).
  - else `branch`=1 and `zero`=1: `pc4` + (sign-extended IR[15:0] << 2).
  - else `pc4`.
- `imem_ack` in VALID ignored; `branch`/`jump`/`zero` outside consume ignored.
- `op_instruction` always equals IR[31:26] combinationally.

## Timing

- Reset (any state, overrides all): state=FETCH, `pc`=`PC_RESET`, IR=0, `instr_valid`=0, `imem_req`=1 from the first cycle after reset deasserts (0 while `rst`=1), counters=0. Ack arriving in the same cycle as `rst` is discarded.
- Ack in cycle N -> `instr_valid`=1 and IR updated in cycle N+1.
- Consume in cycle M -> `imem_req`=1 with new `imem_addr` in cycle M+1.
- Zero-wait memory (ack in first request cycle): one instruction per 2 cycles.
- `instr_valid` never high in the same cycle as `imem_req`.
- Stall asserted for k cycles in VALID extends VALID by exactly k cycles.

## Configuration

- `IFETCH_PERF_CNT_EN` defined: `retired_cnt` increments by 1 per consume; `stall_cnt` increments by 1 per VALID cycle with `stall`=1; both wrap modulo 2^32, clear on reset.
- Not defined: counter logic omitted; both ports tied to 32'h0.

## Test plan

- Reset + sequential: `PC_RESET`=0, memory acks immediately, no branch/jump -> `imem_addr` 0x0, 0x4, 0x8 on successive FETCH cycles; `instr_valid` toggles every cycle; `op_instruction` matches word[31:26].
- Wait states: ack delayed 3 cycles -> `imem_req`/`imem_addr` stable for 3 cycles, `instr_valid`=1 exactly one cycle after ack.
- Branch taken: `pc`=0x10, IR=0x1000_FFFE (BEQ, imm -2), `branch`=1, `zero`=1 -> next `imem_addr`=0x0C; `zero`=0 -> 0x14.
- Jump: `pc`=0x1000_0020, IR=0x0800_0040, `jump`=1, `branch`=1 -> next `imem_addr`=0x1000_0100.
- Stall + counters (`IFETCH_PERF_CNT_EN` defined): stall 4 cycles on first instruction, then 3 consumes -> IR held during stall, `stall_cnt`=4, `retired_cnt`=3; undefined build -> both 0.
- Reset mid-fetch: assert `rst` in FETCH with `imem_ack`=1 same cycle -> IR stays 0, `pc`=`PC_RESET`, `instr_valid`=0, refetch from `PC_RESET`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch front end with PC, IR and next-PC selection (optional IFETCH_PERF_CNT_EN counters)
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [5:0]  op_instruction,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] pc_next;
    logic        load_ir;
    logic        consume;

    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign instruction    = ir_q;
    assign op_instruction = ir_q[31:26];

    // Next-PC selection: jump beats taken branch, otherwise sequential.
    always_comb begin
        pc4    = pc_q + 32'd4;
        br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        if (jump) begin
            pc_next = {pc4[31:28], ir_q[25:0], 2'b00};
        end else if (branch && zero) begin
            pc_next = pc4 + br_off;
        end else begin
            pc_next = pc4;
        end
    end

    // FSM next state and handshake outputs; request is masked while in reset.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_ir     = 1'b0;
        consume     = 1'b0;
        case (state)
            FETCH: begin
                imem_req = !rst;
                if (imem_ack) begin
                    load_ir    = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC and instruction register; reset wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
            ir_q <= 32'h0;
        end else begin
            if (load_ir) begin
                ir_q <= imem_rdata;
            end
            if (consume) begin
                pc_q <= pc_next;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

    // Retired and stalled-cycle counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 32'h0;
            stall_q   <= 32'h0;
        end else begin
            if (consume) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((state == VALID) && stall) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`else
    assign retired_cnt = 32'h0;
    assign stall_cnt   = 32'h0;
`endif

endmodule
